// File: rtl/sp_bank_unit.sv
// Banked stack-pointer unit: NUM_SP pointers with per-bank bounds, bounds-checked
// push/pop stepping, sticky overflow/underflow flags and a registered fault pulse.
module sp_bank_unit #(
  parameter int               WIDTH      = 32,
  parameter int               NUM_SP     = 4,
  parameter int               STEP       = 4,
  parameter logic [WIDTH-1:0] RESET_SP   = '0,
  parameter logic [WIDTH-1:0] IDLE_VALUE = '0,
  localparam int              SEL_W      = $clog2(NUM_SP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  sel,
  input  logic              we,
  input  logic [WIDTH-1:0]  write_data,
  input  logic              push,
  input  logic              pop,
  input  logic              lim_we,
  input  logic              lim_hi,
  input  logic              flag_clr,
  input  logic              re,
  output logic [WIDTH-1:0]  read_data,
  output logic [NUM_SP-1:0] ovf_flags,
  output logic [NUM_SP-1:0] udf_flags,
  output logic              fault
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0]  r_sp [NUM_SP];
  logic [WIDTH-1:0]  r_lo [NUM_SP];
  logic [WIDTH-1:0]  r_hi [NUM_SP];
  logic [NUM_SP-1:0] r_ovf;
  logic [NUM_SP-1:0] r_udf;
  logic              r_fault;

  logic [WIDTH-1:0]  w_sp_cur;
  logic [WIDTH:0]    w_sp_dec;
  logic [WIDTH:0]    w_sp_inc;
  logic              w_push_go;
  logic              w_pop_go;
  logic              w_ovf_evt;
  logic              w_udf_evt;

  // Extra MSB of the WIDTH+1 result is the borrow (push) or carry (pop).
  function automatic logic push_ok(input logic [WIDTH:0] nx, input logic [WIDTH-1:0] lo);
    return !nx[WIDTH] && (nx[WIDTH-1:0] >= lo);
  endfunction

  function automatic logic pop_ok(input logic [WIDTH:0] nx, input logic [WIDTH-1:0] hi);
    return !nx[WIDTH] && (nx[WIDTH-1:0] <= hi);
  endfunction

  assign w_sp_cur  = r_sp[sel];
  assign w_sp_dec  = {1'b0, w_sp_cur} - STEP_X;
  assign w_sp_inc  = {1'b0, w_sp_cur} + STEP_X;

  // A write overrides stepping; push together with pop cancels out.
  assign w_push_go = push & ~pop & ~we;
  assign w_pop_go  = pop & ~push & ~we;
  assign w_ovf_evt = w_push_go & ~push_ok(w_sp_dec, r_lo[sel]);
  assign w_udf_evt = w_pop_go  & ~pop_ok(w_sp_inc, r_hi[sel]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_SP; b++) begin
        r_sp[b] <= RESET_SP;
        r_lo[b] <= '0;
        r_hi[b] <= '1;
      end
      r_ovf   <= '0;
      r_udf   <= '0;
      r_fault <= 1'b0;
    end else begin
      if (we) begin
        r_sp[sel] <= write_data;
      end else if (w_push_go && !w_ovf_evt) begin
        r_sp[sel] <= w_sp_dec[WIDTH-1:0];
      end else if (w_pop_go && !w_udf_evt) begin
        r_sp[sel] <= w_sp_inc[WIDTH-1:0];
      end
      if (lim_we) begin
        if (lim_hi) begin
          r_hi[sel] <= write_data;
        end else begin
          r_lo[sel] <= write_data;
        end
      end
      // A fault in the same cycle as a clear leaves the flag set.
      r_ovf[sel] <= w_ovf_evt | (r_ovf[sel] & ~flag_clr);
      r_udf[sel] <= w_udf_evt | (r_udf[sel] & ~flag_clr);
      r_fault    <= w_ovf_evt | w_udf_evt;
    end
  end

  assign read_data = re ? w_sp_cur : IDLE_VALUE;
  assign ovf_flags = r_ovf;
  assign udf_flags = r_udf;
  assign fault     = r_fault;

endmodule

// File: tb/tb_sp_bank_unit.sv
// Directed bench for sp_bank_unit: a bank-array model compared every falling edge,
// plus literal expectations at the key points of each scenario.
module tb_sp_bank_unit;

  localparam int          W     = 32;
  localparam int          N     = 4;
  localparam int          STP   = 4;
  localparam logic [31:0] RSP   = 32'h0000_0040;
  localparam logic [31:0] IDLE  = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    sel = '0;
  logic          we = 1'b0, push = 1'b0, pop = 1'b0;
  logic          lim_we = 1'b0, lim_hi = 1'b0, flag_clr = 1'b0, re = 1'b0;
  logic [W-1:0]  write_data = '0;
  logic [W-1:0]  read_data;
  logic [N-1:0]  ovf_flags, udf_flags;
  logic          fault;

  int total = 0;
  int bad   = 0;

  sp_bank_unit #(
    .WIDTH(W), .NUM_SP(N), .STEP(STP), .RESET_SP(RSP), .IDLE_VALUE(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .write_data(write_data),
    .push(push), .pop(pop), .lim_we(lim_we), .lim_hi(lim_hi),
    .flag_clr(flag_clr), .re(re), .read_data(read_data),
    .ovf_flags(ovf_flags), .udf_flags(udf_flags), .fault(fault)
  );

  always #5 clk = ~clk;

  // Model state held as plain integers; legality by ordinary arithmetic.
  longint unsigned m_sp [N];
  longint unsigned m_lo [N];
  longint unsigned m_hi [N];
  logic [N-1:0]    m_ovf, m_udf;
  logic            m_fault;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < N; b++) begin
        m_sp[b] = RSP; m_lo[b] = 0; m_hi[b] = 64'hFFFF_FFFF;
      end
      m_ovf = '0; m_udf = '0; m_fault = 1'b0;
    end else begin
      automatic longint unsigned cur = m_sp[sel];
      automatic bit ovf_e = 0, udf_e = 0;
      if (we) m_sp[sel] = write_data;
      else if (push && !pop) begin
        if (cur >= STP && cur - STP >= m_lo[sel]) m_sp[sel] = cur - STP;
        else ovf_e = 1;
      end else if (pop && !push) begin
        if (cur + STP <= 64'hFFFF_FFFF && cur + STP <= m_hi[sel]) m_sp[sel] = cur + STP;
        else udf_e = 1;
      end
      if (lim_we) begin
        if (lim_hi) m_hi[sel] = write_data;
        else m_lo[sel] = write_data;
      end
      if (flag_clr) begin m_ovf[sel] = 1'b0; m_udf[sel] = 1'b0; end
      if (ovf_e) m_ovf[sel] = 1'b1;
      if (udf_e) m_udf[sel] = 1'b1;
      m_fault = ovf_e | udf_e;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_read", read_data, re ? 32'(m_sp[sel]) : IDLE);
    check("model_ovf", 32'(ovf_flags), 32'(m_ovf));
    check("model_udf", 32'(udf_flags), 32'(m_udf));
    check("model_fault", 32'(fault), 32'(m_fault));
  end

  task automatic cyc(input logic [1:0] s, input logic w, input logic p, input logic q,
                     input logic lw, input logic lh, input logic fc, input logic [31:0] d);
    sel = s; we = w; push = p; pop = q; lim_we = lw; lim_hi = lh; flag_clr = fc;
    write_data = d; re = 1'b1;
    @(posedge clk); #1;
    we = 0; push = 0; pop = 0; lim_we = 0; lim_hi = 0; flag_clr = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    re = 1'b0; sel = 2'd2; #1;
    check("idle_read", read_data, IDLE);
    re = 1'b1; #1;
    check("reset_sp2", read_data, RSP);
    check("reset_flags", 32'({ovf_flags, udf_flags, fault}), 32'h0);

    // Bank 1 push stepping down to LO and one past it
    cyc(2'd1, 1, 0, 0, 0, 0, 0, 32'h1000);
    cyc(2'd1, 0, 0, 0, 1, 0, 0, 32'h0FF8);
    cyc(2'd1, 0, 1, 0, 0, 0, 0, 32'h0);
    check("push1", read_data, 32'h0FFC);
    cyc(2'd1, 0, 1, 0, 0, 0, 0, 32'h0);
    check("push2", read_data, 32'h0FF8);
    check("push2_fault", 32'(fault), 32'h0);
    cyc(2'd1, 0, 1, 0, 0, 0, 0, 32'h0);
    check("push3_sp", read_data, 32'h0FF8);
    check("push3_ovf", 32'(ovf_flags), 32'h2);
    check("push3_fault", 32'(fault), 32'h1);
    cyc(2'd1, 0, 0, 0, 0, 0, 0, 32'h0);
    check("fault_drop", 32'(fault), 32'h0);
    sel = 2'd0; #1;
    check("bank0_untouched", read_data, RSP);

    // Bank 0 carry on pop, borrow on push
    cyc(2'd0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    cyc(2'd0, 0, 0, 1, 0, 0, 0, 32'h0);
    check("pop_carry_sp", read_data, 32'hFFFF_FFFC);
    check("pop_carry_udf", 32'(udf_flags), 32'h1);
    check("pop_carry_fault", 32'(fault), 32'h1);
    cyc(2'd0, 1, 0, 0, 0, 0, 0, 32'h2);
    cyc(2'd0, 0, 1, 0, 0, 0, 0, 32'h0);
    check("push_borrow_sp", read_data, 32'h2);
    check("push_borrow_ovf", 32'(ovf_flags), 32'h3);

    // Simultaneous requests
    cyc(2'd0, 1, 1, 0, 0, 0, 0, 32'h500);
    check("we_push_sp", read_data, 32'h500);
    check("we_push_fault", 32'(fault), 32'h0);
    cyc(2'd0, 0, 1, 1, 0, 0, 0, 32'h0);
    check("push_pop_sp", read_data, 32'h500);
    check("push_pop_fault", 32'(fault), 32'h0);
    cyc(2'd0, 1, 0, 0, 0, 0, 0, 32'h2);
    cyc(2'd0, 0, 1, 0, 0, 0, 1, 32'h0);
    check("clr_vs_fault", 32'(ovf_flags), 32'h3);
    cyc(2'd0, 0, 0, 0, 0, 0, 1, 32'h0);
    check("clr_ovf", 32'(ovf_flags), 32'h2);
    check("clr_udf", 32'(udf_flags), 32'h0);

    // Bound written alongside a push only applies from the next cycle
    cyc(2'd2, 1, 0, 0, 0, 0, 0, 32'h104);
    cyc(2'd2, 0, 1, 0, 1, 0, 0, 32'h100);
    check("old_lo_sp", read_data, 32'h100);
    check("old_lo_fault", 32'(fault), 32'h0);
    cyc(2'd2, 0, 1, 0, 0, 0, 0, 32'h0);
    check("new_lo_sp", read_data, 32'h100);
    check("new_lo_fault", 32'(fault), 32'h1);
    check("new_lo_ovf", 32'(ovf_flags), 32'h6);

    // HI bound on pop: landing exactly on HI is legal, beyond is not
    cyc(2'd3, 0, 0, 0, 1, 1, 0, 32'h200);
    cyc(2'd3, 1, 0, 0, 0, 0, 0, 32'h1FC);
    cyc(2'd3, 0, 0, 1, 0, 0, 0, 32'h0);
    check("pop_to_hi", read_data, 32'h200);
    cyc(2'd3, 0, 0, 1, 0, 0, 0, 32'h0);
    check("pop_past_hi", read_data, 32'h200);
    check("pop_past_hi_udf", 32'(udf_flags), 32'h8);
    check("back_to_back_fault", 32'(fault), 32'h1);

    // Asynchronous reset while a fault pulse is high
    cyc(2'd1, 0, 1, 0, 0, 0, 0, 32'h0);
    check("pre_rst_fault", 32'(fault), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_fault", 32'(fault), 32'h0);
    check("async_sp1", read_data, RSP);
    check("async_flags", 32'({ovf_flags, udf_flags}), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    cyc(2'd1, 0, 1, 0, 0, 0, 0, 32'h0);
    check("post_rst_push", read_data, RSP - 32'(STP));
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
